// File: rtl/ysyx_210184_if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request, registers inst/pc/valid into decode.
// Optional performance counters are enabled by defining YSYX_210184_IF_PERF_EN.

module ysyx_210184_if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req_o,
  output logic [63:0] if_addr_o,
  input  logic        if_ready_i,
  input  logic [31:0] if_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [63:0] flush_pc_i,
  input  logic        jal_i,
  input  logic [63:0] jal_off_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        inst_valid_o
`ifdef YSYX_210184_IF_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt_o,
  output logic [63:0] perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    KILL,
    HOLD
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic [63:0] r_pc;
  logic [63:0] r_addr;
  logic [31:0] r_inst;
  logic [63:0] r_pc_o;
  logic        r_valid;
  logic [31:0] r_buf_inst;
  logic [63:0] r_buf_pc;

  logic        w_hs;
  logic        w_jal_take;
  logic        w_redir;
  logic [63:0] w_flush_tgt;
  logic [63:0] w_jal_tgt;
  logic [63:0] w_tgt;

  assign w_hs        = r_req & if_ready_i;
  assign w_jal_take  = jal_i & ~stall_i;
  assign w_redir     = flush_i | w_jal_take;
  assign w_flush_tgt = flush_pc_i & ~64'd3;
  assign w_jal_tgt   = (r_pc_o + jal_off_i) & ~64'd3;
  assign w_tgt       = flush_i ? w_flush_tgt : w_jal_tgt;

  // Fetch control; r_pc is the next PC to fetch, r_addr the address held on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_inst     <= NOP_INST;
      r_pc_o     <= 64'd0;
      r_valid    <= 1'b0;
      r_buf_inst <= NOP_INST;
      r_buf_pc   <= 64'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
          if (flush_i) begin
            r_pc   <= w_flush_tgt;
            r_addr <= w_flush_tgt;
          end else begin
            r_addr <= r_pc;
          end
        end

        FETCH: begin
          if (w_redir) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_pc    <= w_tgt;
            // A pending request must stay stable; its data is discarded in KILL.
            if (r_req && !if_ready_i) begin
              r_state <= KILL;
            end else begin
              r_addr <= w_tgt;
              r_req  <= 1'b1;
            end
          end else if (w_hs) begin
            if (stall_i) begin
              r_buf_inst <= if_rdata_i;
              r_buf_pc   <= r_addr;
              r_req      <= 1'b0;
              r_state    <= HOLD;
            end else begin
              r_inst  <= if_rdata_i;
              r_pc_o  <= r_addr;
              r_valid <= 1'b1;
              r_pc    <= r_addr + 64'd4;
              r_addr  <= r_addr + 64'd4;
            end
          end else if (!r_req) begin
            r_req  <= 1'b1;
            r_addr <= r_pc;
          end
        end

        KILL: begin
          if (flush_i) begin
            r_pc <= w_flush_tgt;
          end
          if (if_ready_i) begin
            r_state <= FETCH;
            r_addr  <= flush_i ? w_flush_tgt : r_pc;
          end
        end

        HOLD: begin
          if (w_redir) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
            r_pc    <= w_tgt;
            r_addr  <= w_tgt;
            r_req   <= 1'b1;
            r_state <= FETCH;
          end else if (!stall_i) begin
            r_inst  <= r_buf_inst;
            r_pc_o  <= r_buf_pc;
            r_valid <= 1'b1;
            r_pc    <= r_buf_pc + 64'd4;
            r_addr  <= r_buf_pc + 64'd4;
            r_req   <= 1'b1;
            r_state <= FETCH;
          end
        end

        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign if_req_o     = r_req;
  assign if_addr_o    = r_addr;
  assign inst_o       = r_inst;
  assign pc_o         = r_pc_o;
  assign inst_valid_o = r_valid;

`ifdef YSYX_210184_IF_PERF_EN
  logic [63:0] r_fetch_cnt;
  logic [63:0] r_stall_cnt;

  // Useful fetches are handshakes in FETCH that are not dropped by a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= 64'd0;
      r_stall_cnt <= 64'd0;
    end else begin
      if ((r_state == FETCH) && w_hs && !w_redir) begin
        r_fetch_cnt <= r_fetch_cnt + 64'd1;
      end
      if (r_req && !if_ready_i) begin
        r_stall_cnt <= r_stall_cnt + 64'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = r_fetch_cnt;
  assign perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ysyx_210184_if_stage.sv
// Self-checking bench for ysyx_210184_if_stage: directed scenarios plus a randomized
// run checked by a program-order scoreboard (next expected PC and address-derived data).

module tb_ysyx_210184_if_stage;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        if_req_o;
  logic [63:0] if_addr_o;
  logic        if_ready_i;
  logic [31:0] if_rdata_i;
  logic        stall_i;
  logic        flush_i;
  logic [63:0] flush_pc_i;
  logic        jal_i;
  logic [63:0] jal_off_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        inst_valid_o;
`ifdef YSYX_210184_IF_PERF_EN
  logic [63:0] perf_fetch_cnt_o;
  logic [63:0] perf_stall_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  ysyx_210184_if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_o     (if_req_o),
    .if_addr_o    (if_addr_o),
    .if_ready_i   (if_ready_i),
    .if_rdata_i   (if_rdata_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .jal_i        (jal_i),
    .jal_off_i    (jal_off_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_valid_o (inst_valid_o)
`ifdef YSYX_210184_IF_PERF_EN
    ,
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  // Full view, view without pc_o (pc_o is unspecified while invalid), view without address.
  wire [161:0] obs_f = {if_req_o, if_addr_o, inst_valid_o, pc_o, inst_o};
  wire [97:0]  obs_n = {if_req_o, if_addr_o, inst_valid_o, inst_o};
  wire [97:0]  obs_h = {if_req_o, inst_valid_o, pc_o, inst_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC3A5_1E00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if_rdata_i = mf(if_addr_o);
  endtask

  task automatic idle_inputs();
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    flush_pc_i = 64'd0;
    jal_i      = 1'b0;
    jal_off_i  = 64'd0;
    if_ready_i = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    if_rdata_i = mf(if_addr_o);
  endtask

  task automatic test_reset();
    logic [161:0] e;
    idle_inputs();
    rst = 1'b1;
    if_rdata_i = 32'd0;
    #1;
    e = {1'b1 ^ 1'b1, RPC, 1'b0, 64'd0, NOP};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL reset_async got %h exp %h", obs_f, e); end
    step();
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL reset_clocked got %h exp %h", obs_f, e); end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [161:0] e;
    logic [97:0]  en;
    do_reset();
    step();
    en = {1'b1, RPC, 1'b0, NOP};
    n_vec++;
    if (obs_n !== en) begin n_err++; $display("FAIL zw_c1 got %h exp %h", obs_n, en); end
    step();
    e = {1'b1, RPC + 64'd4, 1'b1, RPC, mf(RPC)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL zw_c2 got %h exp %h", obs_f, e); end
    step();
    e = {1'b1, RPC + 64'd8, 1'b1, RPC + 64'd4, mf(RPC + 64'd4)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL zw_c3 got %h exp %h", obs_f, e); end
  endtask

  task automatic test_wait_states();
    logic [161:0] e;
    do_reset();
    step();
    step();
    if_ready_i = 1'b0;
    e = {1'b1, RPC + 64'd4, 1'b1, RPC, mf(RPC)};
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (obs_f !== e) begin n_err++; $display("FAIL ws_hold%0d got %h exp %h", i, obs_f, e); end
    end
`ifdef YSYX_210184_IF_PERF_EN
    n_vec++;
    if (perf_stall_cnt_o !== 64'd3) begin
      n_err++; $display("FAIL ws_perf_stall got %0d exp 3", perf_stall_cnt_o);
    end
`endif
    if_ready_i = 1'b1;
    step();
    e = {1'b1, RPC + 64'd8, 1'b1, RPC + 64'd4, mf(RPC + 64'd4)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL ws_done got %h exp %h", obs_f, e); end
`ifdef YSYX_210184_IF_PERF_EN
    n_vec++;
    if (perf_fetch_cnt_o !== 64'd2) begin
      n_err++; $display("FAIL ws_perf_fetch got %0d exp 2", perf_fetch_cnt_o);
    end
`endif
  endtask

  task automatic test_stall_hold();
    logic [161:0] e;
    logic [97:0]  eh;
    do_reset();
    step();
    step();
    stall_i = 1'b1;
    eh = {1'b0, 1'b1, RPC, mf(RPC)};
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (obs_h !== eh) begin n_err++; $display("FAIL sh_hold%0d got %h exp %h", i, obs_h, eh); end
    end
    stall_i = 1'b0;
    step();
    e = {1'b1, RPC + 64'd8, 1'b1, RPC + 64'd4, mf(RPC + 64'd4)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL sh_release got %h exp %h", obs_f, e); end
    step();
    e = {1'b1, RPC + 64'd12, 1'b1, RPC + 64'd8, mf(RPC + 64'd8)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL sh_next got %h exp %h", obs_f, e); end
  endtask

  task automatic test_jal();
    logic [161:0] e;
    logic [97:0]  en;
    do_reset();
    repeat (6) step();
    e = {1'b1, RPC + 64'h14, 1'b1, RPC + 64'h10, mf(RPC + 64'h10)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL jal_pre got %h exp %h", obs_f, e); end
    jal_i = 1'b1;
    jal_off_i = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    jal_i = 1'b0;
    en = {1'b1, RPC + 64'h8, 1'b0, NOP};
    n_vec++;
    if (obs_n !== en) begin n_err++; $display("FAIL jal_bubble got %h exp %h", obs_n, en); end
    step();
    e = {1'b1, RPC + 64'hC, 1'b1, RPC + 64'h8, mf(RPC + 64'h8)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL jal_target got %h exp %h", obs_f, e); end
    // jal under stall is ignored while the request waits
    stall_i = 1'b1;
    jal_i = 1'b1;
    if_ready_i = 1'b0;
    step();
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL jal_stall_ignored got %h exp %h", obs_f, e); end
    stall_i = 1'b0;
    jal_i = 1'b0;
    if_ready_i = 1'b1;
    step();
    e = {1'b1, RPC + 64'h10, 1'b1, RPC + 64'hC, mf(RPC + 64'hC)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL jal_seq got %h exp %h", obs_f, e); end
  endtask

  task automatic test_jal_wrap();
    logic [161:0] e;
    logic [97:0]  en;
    do_reset();
    step();
    flush_i = 1'b1;
    flush_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    flush_i = 1'b0;
    step();
    e = {1'b1, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, mf(64'hFFFF_FFFF_FFFF_FFFC)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL wrap_seq got %h exp %h", obs_f, e); end
    jal_i = 1'b1;
    jal_off_i = 64'd9;
    step();
    jal_i = 1'b0;
    en = {1'b1, 64'd4, 1'b0, NOP};
    n_vec++;
    if (obs_n !== en) begin n_err++; $display("FAIL wrap_jal got %h exp %h", obs_n, en); end
  endtask

  task automatic test_flush_kill();
    logic [161:0] e;
    logic [97:0]  en;
    do_reset();
    step();
    step();
    if_ready_i = 1'b0;
    flush_i = 1'b1;
    flush_pc_i = RPC + 64'h100;
    step();
    flush_i = 1'b0;
    en = {1'b1, RPC + 64'd4, 1'b0, NOP};
    n_vec++;
    if (obs_n !== en) begin n_err++; $display("FAIL fk_enter got %h exp %h", obs_n, en); end
    step();
    n_vec++;
    if (obs_n !== en) begin n_err++; $display("FAIL fk_wait got %h exp %h", obs_n, en); end
    if_ready_i = 1'b1;
    step();
    en = {1'b1, RPC + 64'h100, 1'b0, NOP};
    n_vec++;
    if (obs_n !== en) begin n_err++; $display("FAIL fk_drop got %h exp %h", obs_n, en); end
    step();
    e = {1'b1, RPC + 64'h104, 1'b1, RPC + 64'h100, mf(RPC + 64'h100)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL fk_target got %h exp %h", obs_f, e); end
    // second flush during KILL replaces the target
    if_ready_i = 1'b0;
    flush_i = 1'b1;
    flush_pc_i = RPC + 64'h180;
    step();
    flush_pc_i = RPC + 64'h1C1;
    step();
    flush_i = 1'b0;
    if_ready_i = 1'b1;
    step();
    en = {1'b1, RPC + 64'h1C0, 1'b0, NOP};
    n_vec++;
    if (obs_n !== en) begin n_err++; $display("FAIL fk_overwrite got %h exp %h", obs_n, en); end
  endtask

  task automatic test_flush_priority();
    logic [161:0] e;
    logic [97:0]  en;
    do_reset();
    step();
    step();
    flush_i = 1'b1;
    flush_pc_i = RPC + 64'h203;
    jal_i = 1'b1;
    jal_off_i = 64'h40;
    step();
    flush_i = 1'b0;
    jal_i = 1'b0;
    en = {1'b1, RPC + 64'h200, 1'b0, NOP};
    n_vec++;
    if (obs_n !== en) begin n_err++; $display("FAIL fp_flush_over_jal got %h exp %h", obs_n, en); end
    step();
    e = {1'b1, RPC + 64'h204, 1'b1, RPC + 64'h200, mf(RPC + 64'h200)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL fp_target got %h exp %h", obs_f, e); end
    stall_i = 1'b1;
    flush_i = 1'b1;
    flush_pc_i = RPC + 64'h300;
    step();
    flush_i = 1'b0;
    en = {1'b1, RPC + 64'h300, 1'b0, NOP};
    n_vec++;
    if (obs_n !== en) begin n_err++; $display("FAIL fp_flush_in_stall got %h exp %h", obs_n, en); end
    stall_i = 1'b0;
    step();
    e = {1'b1, RPC + 64'h304, 1'b1, RPC + 64'h300, mf(RPC + 64'h300)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL fp_stall_target got %h exp %h", obs_f, e); end
    stall_i = 1'b1;
    step();
    flush_i = 1'b1;
    flush_pc_i = RPC + 64'h400;
    step();
    flush_i = 1'b0;
    en = {1'b1, RPC + 64'h400, 1'b0, NOP};
    n_vec++;
    if (obs_n !== en) begin n_err++; $display("FAIL fp_flush_hold got %h exp %h", obs_n, en); end
    stall_i = 1'b0;
    step();
    e = {1'b1, RPC + 64'h404, 1'b1, RPC + 64'h400, mf(RPC + 64'h400)};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL fp_hold_target got %h exp %h", obs_f, e); end
  endtask

  task automatic test_reset_mid();
    logic [161:0] e;
    do_reset();
    step();
    step();
    if_ready_i = 1'b0;
    step();
    rst = 1'b1;
    #1;
    e = {1'b0, RPC, 1'b0, 64'd0, NOP};
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL rm_async got %h exp %h", obs_f, e); end
    if_ready_i = 1'b1;
    step();
    n_vec++;
    if (obs_f !== e) begin n_err++; $display("FAIL rm_ignore_ready got %h exp %h", obs_f, e); end
    rst = 1'b0;
  endtask

  // Program-order scoreboard: each newly delivered instruction must be at the next expected PC.
  task automatic test_random();
    logic [63:0] exp_next;
    logic [63:0] tgt;
    logic [63:0] addr_before;
    logic [63:0] prev_pc;
    logic [31:0] prev_inst;
    logic        pend;
    logic        prev_valid;
    logic        redir;
    logic        new_del;
    int          ndel;
    do_reset();
    exp_next   = RPC;
    prev_valid = 1'b0;
    prev_pc    = 64'd0;
    prev_inst  = NOP;
    ndel       = 0;
    for (int c = 0; c < 3000; c++) begin
      stall_i    = ($urandom_range(0, 99) < 30);
      if_ready_i = ($urandom_range(0, 99) < 65);
      flush_i    = ($urandom_range(0, 99) < 4);
      flush_pc_i = RPC + 64'($urandom_range(0, 1023));
      jal_i      = inst_valid_o && ($urandom_range(0, 99) < 12);
      jal_off_i  = 64'($urandom_range(0, 131)) - 64'd64;
      redir      = flush_i || (jal_i && !stall_i);
      tgt        = flush_i ? (flush_pc_i & ~64'd3) : ((pc_o + jal_off_i) & ~64'd3);
      pend       = if_req_o && !if_ready_i;
      addr_before = if_addr_o;
      step();
      if (pend) begin
        n_vec++;
        if (!if_req_o || if_addr_o !== addr_before) begin
          n_err++;
          $display("FAIL rnd_stable c=%0d got req=%b addr=%h exp req=1 addr=%h", c, if_req_o, if_addr_o, addr_before);
        end
      end
      if (!inst_valid_o) begin
        n_vec++;
        if (inst_o !== NOP) begin n_err++; $display("FAIL rnd_nop c=%0d got %h exp %h", c, inst_o, NOP); end
      end
      new_del = inst_valid_o && (!prev_valid || pc_o != prev_pc);
      if (redir) begin
        exp_next = tgt;
        n_vec++;
        if (inst_valid_o !== 1'b0) begin
          n_err++; $display("FAIL rnd_redir_bubble c=%0d got valid=%b exp 0", c, inst_valid_o);
        end
      end else if (new_del) begin
        ndel++;
        n_vec++;
        if (pc_o !== exp_next || inst_o !== mf(exp_next)) begin
          n_err++;
          $display("FAIL rnd_order c=%0d got pc=%h inst=%h exp pc=%h inst=%h", c, pc_o, inst_o, exp_next, mf(exp_next));
        end
        exp_next = pc_o + 64'd4;
      end else if (inst_valid_o) begin
        n_vec++;
        if (inst_o !== prev_inst) begin
          n_err++; $display("FAIL rnd_held c=%0d got %h exp %h", c, inst_o, prev_inst);
        end
      end
      prev_valid = inst_valid_o;
      prev_pc    = pc_o;
      prev_inst  = inst_o;
    end
    idle_inputs();
    n_vec++;
    if (ndel < 300) begin n_err++; $display("FAIL rnd_progress got %0d deliveries exp >= 300", ndel); end
  endtask

  initial begin
    rst = 1'b1;
    if_rdata_i = 32'd0;
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_jal();
    test_jal_wrap();
    test_flush_kill();
    test_flush_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
